// File: rtl/au_result_buffer_pkg.sv
// Shared definitions for the arithmetic-unit result buffer: data widths,
// op-tag constants, the occupancy state encoding and the entry parity helper.
// Optional feature macro: AU_RB_PARITY_EN (adds a stored parity bit per entry).
package au_result_buffer_pkg;

  localparam int AU_Y_W     = 4;
  localparam int AU_ENTRY_W = 5;

  localparam logic AU_OP_MUL = 1'b0;
  localparam logic AU_OP_ADD = 1'b1;

`ifdef AU_RB_PARITY_EN
  localparam int AU_MEM_W = AU_ENTRY_W + 1;
`else
  localparam int AU_MEM_W = AU_ENTRY_W;
`endif

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } occ_state_t;

  // Even parity over one {sel, y} entry.
  function automatic logic entry_parity(input logic [AU_ENTRY_W-1:0] e);
    return ^e;
  endfunction

endpackage

// File: rtl/au_result_buffer_if.sv
// Producer/consumer handshake bundle of the result buffer.
// slave = buffer side, master = producer/consumer (test) side.
// Optional feature macro: AU_RB_PARITY_EN (adds out_parity).
interface au_result_buffer_if;
  import au_result_buffer_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [AU_Y_W-1:0]     in_y;
  logic                  in_sel;
  logic                  out_valid;
  logic                  out_ready;
  logic [AU_ENTRY_W-1:0] out_data;
`ifdef AU_RB_PARITY_EN
  logic                  out_parity;
`endif

`ifdef AU_RB_PARITY_EN
  modport slave  (input  in_valid, in_y, in_sel, out_ready,
                  output in_ready, out_valid, out_data, out_parity);
  modport master (output in_valid, in_y, in_sel, out_ready,
                  input  in_ready, out_valid, out_data, out_parity);
`else
  modport slave  (input  in_valid, in_y, in_sel, out_ready,
                  output in_ready, out_valid, out_data);
  modport master (output in_valid, in_y, in_sel, out_ready,
                  input  in_ready, out_valid, out_data);
`endif

endinterface

// File: rtl/au_rb_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
// Contents are never reset; validity is tracked by the owner's pointers.
module au_rb_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: store the entry at the write address on a push.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/au_result_buffer.sv
// Result buffer behind the 2-bit arithmetic unit: first-word-fall-through
// FIFO of {sel, y} entries with a valid/ready handshake on both sides, plus a
// running accumulator of accepted results with a sticky overflow flag.
// Optional feature macro: AU_RB_PARITY_EN (stored parity bit, out_parity port).
module au_result_buffer
  import au_result_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ACC_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  au_result_buffer_if.slave      bus,
  input  logic                   clr,
  output logic [$clog2(DEPTH):0] count,
  output logic [ACC_W-1:0]       acc,
  output logic                   acc_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  occ_state_t          state_q;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                acc_ovf_q, acc_ovf_d;
  logic                push, pop;
  logic                in_ready, out_valid;
  logic [AU_MEM_W-1:0] wr_entry, rd_entry;
  logic [ACC_W:0]      acc_sum;

  // Widening add; the extra top bit is the carry-out feeding the sticky flag.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [AU_Y_W-1:0] y);
    return {1'b0, a} + {{(ACC_W + 1 - AU_Y_W){1'b0}}, y};
  endfunction

  // Handshake decodes come from the registered state only, so a full buffer
  // never accepts even when the consumer pops in the same cycle.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;

`ifdef AU_RB_PARITY_EN
  assign wr_entry = {entry_parity({bus.in_sel, bus.in_y}), bus.in_sel, bus.in_y};
`else
  assign wr_entry = {bus.in_sel, bus.in_y};
`endif

  au_rb_mem #(
    .DEPTH (DEPTH),
    .WIDTH (AU_MEM_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  // Stale array contents are masked so the head reads as zero when empty.
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? rd_entry[AU_ENTRY_W-1:0] : '0;
`ifdef AU_RB_PARITY_EN
  assign bus.out_parity = out_valid & ~rst & rd_entry[AU_ENTRY_W];
`endif

  assign count   = count_q;
  assign acc     = acc_q;
  assign acc_ovf = acc_ovf_q;
  assign acc_sum = acc_add(acc_q, bus.in_y);

  // Pointer and occupancy next-state; pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Accumulator next-state; clear wins over accumulation but still loads a
  // result pushed in the same cycle.
  always_comb begin
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    if (clr) begin
      acc_ovf_d = 1'b0;
      acc_d     = push ? ACC_W'(bus.in_y) : '0;
    end else if (push) begin
      acc_d     = acc_sum[ACC_W-1:0];
      acc_ovf_d = acc_ovf_q | acc_sum[ACC_W];
    end
  end

  // Occupancy FSM with pointer, count and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      case (state_q)
        ST_EMPTY: begin
          if (push) state_q <= ST_PARTIAL;
        end
        ST_PARTIAL: begin
          if (push && !pop && count_q == CNT_W'(DEPTH - 1)) begin
            state_q <= ST_FULL;
          end else if (pop && !push && count_q == CNT_W'(1)) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) state_q <= ST_PARTIAL;
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_au_result_buffer.sv
// Self-checking bench for au_result_buffer: directed vector table, hand-built
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_au_result_buffer;
  import au_result_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int ACC_W = 8;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic [CNT_W-1:0] count;
  logic [ACC_W-1:0] acc;
  logic             acc_ovf;

  int total = 0;
  int bad   = 0;

  au_result_buffer_if bus();

  au_result_buffer #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .clr     (clr),
    .count   (count),
    .acc     (acc),
    .acc_ovf (acc_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, iv, sel;
    logic [3:0] y;
    logic       ordy, c;
    logic [2:0] cnt;
    logic       ov, ir;
    logic [4:0] od;
    logic [7:0] a;
    logic       f;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t v(input logic r, iv, sel, input logic [3:0] y,
                             input logic ordy, c, input logic [2:0] cnt,
                             input logic ov, ir, input logic [4:0] od,
                             input logic [7:0] a, input logic f);
    vec_t t;
    t.r = r; t.iv = iv; t.sel = sel; t.y = y; t.ordy = ordy; t.c = c;
    t.cnt = cnt; t.ov = ov; t.ir = ir; t.od = od; t.a = a; t.f = f;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, iv, sel, input logic [3:0] y, input logic ordy, c);
    rst = r; bus.in_valid = iv; bus.in_sel = sel; bus.in_y = y;
    bus.out_ready = ordy; clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [2:0] cnt, input logic ov, ir,
                             input logic [4:0] od, input logic [7:0] a, input logic f);
    check($sformatf("%s count", tag), 32'(count), 32'(cnt));
    check($sformatf("%s out_valid", tag), 32'(bus.out_valid), 32'(ov));
    check($sformatf("%s in_ready", tag), 32'(bus.in_ready), 32'(ir));
    check($sformatf("%s out_data", tag), 32'(bus.out_data), 32'(od));
    check($sformatf("%s acc", tag), 32'(acc), 32'(a));
    check($sformatf("%s acc_ovf", tag), 32'(acc_ovf), 32'(f));
  endtask

  // Reference model state
  logic [4:0] q[$];
  int         m_acc;
  logic       m_ovf;

  initial begin
    // reset, fill, full-ignore, drain, empty pop, wrap with push+pop, clr
    vecs[0]  = v(1'b1,1'b1,1'b0,4'hF,1'b0,1'b0, 3'd0,1'b0,1'b1,5'h00,8'h00,1'b0);
    vecs[1]  = v(1'b1,1'b1,1'b0,4'hF,1'b0,1'b0, 3'd0,1'b0,1'b1,5'h00,8'h00,1'b0);
    vecs[2]  = v(1'b0,1'b1,1'b0,4'h9,1'b0,1'b0, 3'd1,1'b1,1'b1,5'h09,8'h09,1'b0);
    vecs[3]  = v(1'b0,1'b1,1'b1,4'h5,1'b0,1'b0, 3'd2,1'b1,1'b1,5'h09,8'h0E,1'b0);
    vecs[4]  = v(1'b0,1'b1,1'b0,4'h4,1'b0,1'b0, 3'd3,1'b1,1'b1,5'h09,8'h12,1'b0);
    vecs[5]  = v(1'b0,1'b1,1'b1,4'h3,1'b0,1'b0, 3'd4,1'b1,1'b0,5'h09,8'h15,1'b0);
    vecs[6]  = v(1'b0,1'b1,1'b0,4'h7,1'b0,1'b0, 3'd4,1'b1,1'b0,5'h09,8'h15,1'b0);
    vecs[7]  = v(1'b0,1'b0,1'b0,4'h0,1'b1,1'b0, 3'd3,1'b1,1'b1,5'h15,8'h15,1'b0);
    vecs[8]  = v(1'b0,1'b0,1'b0,4'h0,1'b1,1'b0, 3'd2,1'b1,1'b1,5'h04,8'h15,1'b0);
    vecs[9]  = v(1'b0,1'b0,1'b0,4'h0,1'b1,1'b0, 3'd1,1'b1,1'b1,5'h13,8'h15,1'b0);
    vecs[10] = v(1'b0,1'b0,1'b0,4'h0,1'b1,1'b0, 3'd0,1'b0,1'b1,5'h00,8'h15,1'b0);
    vecs[11] = v(1'b0,1'b0,1'b0,4'h0,1'b1,1'b0, 3'd0,1'b0,1'b1,5'h00,8'h15,1'b0);
    vecs[12] = v(1'b0,1'b1,1'b0,4'h1,1'b0,1'b0, 3'd1,1'b1,1'b1,5'h01,8'h16,1'b0);
    vecs[13] = v(1'b0,1'b1,1'b0,4'h2,1'b0,1'b0, 3'd2,1'b1,1'b1,5'h01,8'h18,1'b0);
    vecs[14] = v(1'b0,1'b1,1'b1,4'h6,1'b1,1'b0, 3'd2,1'b1,1'b1,5'h02,8'h1E,1'b0);
    vecs[15] = v(1'b0,1'b1,1'b1,4'h6,1'b1,1'b0, 3'd2,1'b1,1'b1,5'h16,8'h24,1'b0);
    vecs[16] = v(1'b0,1'b1,1'b1,4'h6,1'b1,1'b0, 3'd2,1'b1,1'b1,5'h16,8'h2A,1'b0);
    vecs[17] = v(1'b0,1'b0,1'b0,4'h0,1'b1,1'b0, 3'd1,1'b1,1'b1,5'h16,8'h2A,1'b0);
    vecs[18] = v(1'b0,1'b0,1'b0,4'h0,1'b1,1'b0, 3'd0,1'b0,1'b1,5'h00,8'h2A,1'b0);
    vecs[19] = v(1'b0,1'b0,1'b0,4'h0,1'b0,1'b1, 3'd0,1'b0,1'b1,5'h00,8'h00,1'b0);

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].r, vecs[i].iv, vecs[i].sel, vecs[i].y, vecs[i].ordy, vecs[i].c);
      tick();
      check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].ir,
                  vecs[i].od, vecs[i].a, vecs[i].f);
    end

    // Accumulator overflow: 18 x 15 = 270 -> 0x0E with carry
    for (int k = 0; k < 18; k++) begin
      drive(1'b0, 1'b1, AU_OP_MUL, 4'hF, 1'b1, 1'b0);
      tick();
    end
    check("ovf acc", 32'(acc), 32'h0E);
    check("ovf flag", 32'(acc_ovf), 32'd1);
    check("ovf count", 32'(count), 32'd1);
    // Sticky across a non-carrying push
    drive(1'b0, 1'b1, AU_OP_MUL, 4'h0, 1'b0, 1'b0);
    tick();
    check("sticky flag", 32'(acc_ovf), 32'd1);
    check("sticky acc", 32'(acc), 32'h0E);
    // Clear together with a push loads the pushed value
    drive(1'b0, 1'b1, AU_OP_ADD, 4'h2, 1'b0, 1'b1);
    tick();
    check("clr acc", 32'(acc), 32'h02);
    check("clr flag", 32'(acc_ovf), 32'd0);
    check("clr count", 32'(count), 32'd3);
    check("clr out_valid", 32'(bus.out_valid), 32'd1);

    // Mid-operation reset with an offered push
    drive(1'b1, 1'b1, AU_OP_ADD, 4'hF, 1'b0, 1'b0);
    tick();
    check_state("midrst", 3'd0, 1'b0, 1'b1, 5'h00, 8'h00, 1'b0);
    drive(1'b0, 1'b1, AU_OP_MUL, 4'h1, 1'b0, 1'b0);
    tick();
    check_state("post-rst push", 3'd1, 1'b1, 1'b1, 5'h01, 8'h01, 1'b0);

`ifdef AU_RB_PARITY_EN
    drive(1'b0, 1'b0, AU_OP_MUL, 4'h0, 1'b1, 1'b0);
    tick();
    check("par empty", 32'(bus.out_parity), 32'd0);
    drive(1'b0, 1'b1, AU_OP_ADD, 4'h7, 1'b0, 1'b0);
    tick();
    check("par 17 data", 32'(bus.out_data), 32'h17);
    check("par 17", 32'(bus.out_parity), 32'd0);
    drive(1'b0, 1'b1, AU_OP_MUL, 4'h7, 1'b1, 1'b0);
    tick();
    check("par 07 data", 32'(bus.out_data), 32'h07);
    check("par 07", 32'(bus.out_parity), 32'd1);
`endif

    // Randomized run against the queue model
    drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    tick();
    q.delete();
    m_acc = 0;
    m_ovf = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      logic r, iv, sel, o, c, do_push, do_pop;
      logic [3:0] y;
      r   = ($urandom_range(0, 99) == 0);
      iv  = 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      y   = 4'($urandom_range(0, 15));
      o   = ($urandom_range(0, 2) != 0);
      c   = ($urandom_range(0, 24) == 0);
      do_push = iv && (q.size() < DEPTH);
      do_pop  = o && (q.size() > 0);
      drive(r, iv, sel, y, o, c);
      tick();
      if (r) begin
        q.delete();
        m_acc = 0;
        m_ovf = 1'b0;
      end else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back({sel, y});
        if (c) begin
          m_acc = do_push ? int'(y) : 0;
          m_ovf = 1'b0;
        end else if (do_push) begin
          m_acc = m_acc + int'(y);
          if (m_acc >= 256) begin
            m_ovf = 1'b1;
            m_acc = m_acc - 256;
          end
        end
      end
      check_state($sformatf("rnd%0d", n), 3'(q.size()), q.size() > 0, q.size() < DEPTH,
                  (q.size() > 0) ? q[0] : 5'h00, 8'(m_acc), m_ovf);
`ifdef AU_RB_PARITY_EN
      check($sformatf("rnd%0d parity", n), 32'(bus.out_parity),
            32'((q.size() > 0) ? ^q[0] : 1'b0));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
